// File: rtl/calc_seq_unit_if.sv
`default_nettype none
// ============================================================================
// Module : calc_seq_unit_if
// Desc   : START/BUSY/DONE request bundle between the operand registers and
//          the multi-cycle arithmetic sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface calc_seq_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        flag_c;
  logic        flag_z;
  logic        err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, flag_c, flag_z, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, flag_c, flag_z, err
  );
endinterface
`default_nettype wire

// File: rtl/calc_seq_unit.sv
`default_nettype none
// ============================================================================
// Module : calc_seq_unit
// Desc   : Multi-cycle ADD/SUB/MUL/DIV sequencer sharing one 8-bit adder.
// Rev    : 1.0  initial release
// ============================================================================
module calc_seq_unit (
  input  logic           clk,
  input  logic           rst,
  calc_seq_unit_if.slave bus
);

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_MUL     = 2'b10;
  localparam logic [1:0] OP_DIV     = 2'b11;
  localparam logic [2:0] LAST_STEP  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  state_t      state_q,  state_d;
  logic [1:0]  op_q,     op_d;
  logic [7:0]  a_q,      a_d;
  logic [7:0]  b_q,      b_d;
  logic [2:0]  cnt_q,    cnt_d;
  logic [15:0] work_q,   work_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;
  logic [15:0] result_q, result_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_z_q, flag_z_d;
  logic        err_q,    err_d;

  logic [7:0]  w_add_a;
  logic [7:0]  w_add_b;
  logic        w_add_cin;
  logic [8:0]  w_add_full;
  logic [7:0]  w_add_sum;
  logic        w_add_cout;
  logic        w_div_ok;
  logic [15:0] w_step_work;
  logic [15:0] w_fin_result;
  logic        w_fin_c;
  logic        w_accept;
  logic        w_div_zero;

  // The single shared adder; subtraction is A + ~B + 1 with borrow = ~cout.
  always_comb begin
    w_add_a   = 8'h00;
    w_add_b   = 8'h00;
    w_add_cin = 1'b0;
    case (op_q)
      OP_ADD: begin
        w_add_a = a_q;
        w_add_b = b_q;
      end
      OP_SUB: begin
        w_add_a   = a_q;
        w_add_b   = ~b_q;
        w_add_cin = 1'b1;
      end
      OP_MUL: begin
        w_add_a = work_q[15:8];
        w_add_b = a_q;
      end
      default: begin
        w_add_a   = work_q[14:7];
        w_add_b   = ~b_q;
        w_add_cin = 1'b1;
      end
    endcase
  end

  assign w_add_full = {1'b0, w_add_a} + {1'b0, w_add_b} + {8'h00, w_add_cin};
  assign w_add_sum  = w_add_full[7:0];
  assign w_add_cout = w_add_full[8];

  // DIV keeps {R, Q} in work_q; the trial value T = {R, Q[7]} is work_q[15:7].
  assign w_div_ok = work_q[15] | w_add_cout;

  always_comb begin
    w_step_work = work_q;
    case (op_q)
      OP_MUL: begin
        if (work_q[0]) begin
          w_step_work = {w_add_cout, w_add_sum, work_q[7:1]};
        end else begin
          w_step_work = {1'b0, work_q[15:1]};
        end
      end
      OP_DIV: begin
        if (w_div_ok) begin
          w_step_work = {w_add_sum, work_q[6:0], 1'b1};
        end else begin
          w_step_work = {work_q[14:7], work_q[6:0], 1'b0};
        end
      end
      default: begin
        w_step_work = work_q;
      end
    endcase
  end

  always_comb begin
    w_fin_result = w_step_work;
    w_fin_c      = 1'b0;
    case (op_q)
      OP_ADD: begin
        w_fin_result = {8'h00, w_add_sum};
        w_fin_c      = w_add_cout;
      end
      OP_SUB: begin
        w_fin_result = {8'h00, w_add_sum};
        w_fin_c      = ~w_add_cout;
      end
      OP_MUL: begin
        w_fin_result = w_step_work;
        w_fin_c      = |w_step_work[15:8];
      end
      default: begin
        w_fin_result = w_step_work;
        w_fin_c      = 1'b0;
      end
    endcase
  end

  assign w_accept   = bus.start & (state_q != ST_EXEC);
  assign w_div_zero = (bus.op == OP_DIV) && (bus.b == 8'h00);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    err_d    = err_q;

    if (state_q != ST_EXEC) begin
      if (w_accept) begin
        op_d = bus.op;
        a_d  = bus.a;
        b_d  = bus.b;
        if (w_div_zero) begin
          // Divide-by-zero never occupies the adder; it reports straight away.
          state_d  = ST_FIN;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = {bus.a, 8'hFF};
          flag_c_d = 1'b0;
          flag_z_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          state_d = ST_EXEC;
          busy_d  = 1'b1;
          cnt_d   = bus.op[1] ? LAST_STEP : 3'd0;
          work_d  = (bus.op == OP_MUL) ? {8'h00, bus.b} : {8'h00, bus.a};
        end
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      work_d = w_step_work;
      if (cnt_q == 3'd0) begin
        state_d  = ST_FIN;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = w_fin_result;
        flag_c_d = w_fin_c;
        flag_z_d = (w_fin_result == 16'h0000);
        err_d    = 1'b0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'b00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cnt_q    <= 3'd0;
      work_q   <= 16'h0000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag_c = flag_c_q;
  assign bus.flag_z = flag_z_q;
  assign bus.err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_calc_seq_unit
// Desc   : Directed scoreboard bench for the calc_seq_unit sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_calc_seq_unit;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  calc_seq_unit_if bus ();

  calc_seq_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every DONE pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.done === 1'b1) begin
      chk("busy_done_exclusive", {31'd0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_result"}, {16'd0, bus.result}, {16'd0, mon_e.res});
        chk({mon_e.name, "_flag_c"}, {31'd0, bus.flag_c}, {31'd0, mon_e.c});
        chk({mon_e.name, "_flag_z"}, {31'd0, bus.flag_z}, {31'd0, mon_e.z});
        chk({mon_e.name, "_err"},    {31'd0, bus.err},    {31'd0, mon_e.e});
        chk({mon_e.name, "_latency"}, cyc - mon_e.issue, mon_e.lat);
      end
    end
  end

  // Drives one request when the unit is not busy; called #1 after a rising edge.
  task automatic issue(input string nm, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] res, input logic c,
                       input logic z, input logic e, input int lat);
    int   guard;
    exp_t x;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: busy got 1 expected 0 after 40 cycles", nm);
    end
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    x.name  = nm;
    x.res   = res;
    x.c     = c;
    x.z     = z;
    x.e     = e;
    x.lat   = lat;
    x.issue = cyc;
    sb.push_back(x);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 60) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 60) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: pending got %0d expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"},   {31'd0, bus.busy},   32'd0);
    chk({nm, "_done"},   {31'd0, bus.done},   32'd0);
    chk({nm, "_result"}, {16'd0, bus.result}, 32'd0);
    chk({nm, "_flag_c"}, {31'd0, bus.flag_c}, 32'd0);
    chk({nm, "_flag_z"}, {31'd0, bus.flag_z}, 32'd0);
    chk({nm, "_err"},    {31'd0, bus.err},    32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Single-pass ops, issued back-to-back as each completes
    issue("add_f0_20", OP_ADD, 8'hF0, 8'h20, 16'h0010, 1'b1, 1'b0, 1'b0, 2);
    issue("sub_5_7",   OP_SUB, 8'd5,  8'd7,  16'h00FE, 1'b1, 1'b0, 1'b0, 2);
    issue("sub_9_9",   OP_SUB, 8'd9,  8'd9,  16'h0000, 1'b0, 1'b1, 1'b0, 2);
    issue("add_ff_01", OP_ADD, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1, 1'b0, 2);
    drain("single");
    repeat (3) @(posedge clk);
    #1;

    // Multiply
    issue("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, 1'b0, 9);
    issue("mul_0_123", OP_MUL, 8'd0,  8'd123, 16'h0000, 1'b0, 1'b1, 1'b0, 9);
    issue("mul_13_11", OP_MUL, 8'd13, 8'd11, 16'h008F, 1'b0, 1'b0, 1'b0, 9);
    drain("mul");

    // Divide, including divisor above 128 and divide-by-zero
    issue("div_200_7",   OP_DIV, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 1'b0, 9);
    issue("div_77_0",    OP_DIV, 8'd77,  8'd0,   16'h4DFF, 1'b0, 1'b0, 1'b1, 1);
    issue("div_255_16",  OP_DIV, 8'd255, 8'd16,  16'h0F0F, 1'b0, 1'b0, 1'b0, 9);
    issue("div_5_9",     OP_DIV, 8'd5,   8'd9,   16'h0500, 1'b0, 1'b0, 1'b0, 9);
    issue("div_255_200", OP_DIV, 8'd255, 8'd200, 16'h3701, 1'b0, 1'b0, 1'b0, 9);
    issue("div_0_0",     OP_DIV, 8'd0,   8'd0,   16'h00FF, 1'b0, 1'b0, 1'b1, 1);
    drain("div");
    repeat (2) @(posedge clk);
    #1;

    // START during EXEC must be ignored; the following ADD lands in the DONE cycle
    issue("mul_12_10", OP_MUL, 8'd12, 8'd10, 16'h0078, 1'b0, 1'b0, 1'b0, 9);
    repeat (2) @(posedge clk);
    #1;
    bus.op    = OP_ADD;
    bus.a     = 8'd1;
    bus.b     = 8'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    issue("b2b_add_3_4", OP_ADD, 8'd3, 8'd4, 16'h0007, 1'b0, 1'b0, 1'b0, 2);
    drain("ignore");
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a divide aborts it without DONE
    issue("div_abort", OP_DIV, 8'd200, 8'd7, 16'h041C, 1'b0, 1'b0, 1'b0, 9);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    sb.delete();
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue("add_after_rst", OP_ADD, 8'h22, 8'h11, 16'h0033, 1'b0, 1'b0, 1'b0, 2);
    drain("post_reset");
    repeat (12) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_seq_unit.md
# calc_seq_unit

Multi-cycle arithmetic sequencer for the calculator datapath. It accepts one operation at a time through a START/BUSY/DONE handshake and time-shares a single 8-bit ripple adder, used in add mode or in two's-complement subtract mode (inverted B, carry-in 1), across four operations:
- ADD and SUB: single pass.
- MUL: 8-step shift-and-add.
- DIV: 8-step restoring division.

It sits between the keypad/operand registers and the result display logic.

## Interface
Parameters:
- none (datapath width fixed at 8 bits; product/quotient-remainder width 16 bits)

Ports:
- CLK  input  1  single clock, rising edge
- RST  input  1  asynchronous, active-high reset
- START  input  1  request; sampled only when BUSY=0
- OP  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV; latched with START
- A  input  8  operand A (minuend / multiplicand / dividend); latched with START
- B  input  8  operand B (subtrahend / multiplier / divisor); latched with START
- BUSY  output  1  high while in EXEC
- DONE  output  1  one-cycle pulse, result valid
- RESULT  output  16  see Operation; held until the next accepted START
- FLAG_C  output  1  carry/borrow/overflow per OP
- FLAG_Z  output  1  RESULT == 16'h0000
- ERR  output  1  divide-by-zero; held with RESULT

## Operation
States: IDLE, EXEC, FIN.

Transitions:
- IDLE/FIN → EXEC: START=1. Latches OP, A, B; loads the step counter.
- IDLE/FIN → FIN: START=1 with OP=DIV and B=0. EXEC is skipped.
- EXEC → FIN: final step completes (ADD/SUB after 1 step, MUL/DIV after 8 steps).
- FIN → IDLE: START=0.
- START while in EXEC is ignored: not queued, latched operands unchanged.

Shared adder: exactly one 8-bit add per EXEC cycle. SUB and the DIV trial subtract drive the adder with ~operand and CIN=1; borrow = ~carry-out.

Per-operation results:
- ADD
  - RESULT = {8'h00, A+B[7:0]}
  - FLAG_C = carry-out
- SUB
  - RESULT = {8'h00, (A−B) mod 256}
  - FLAG_C = borrow (1 when A<B)
- MUL: 16-bit register P, initialised {8'h00, B}. Each step:
  - if P[0]=1: {c, s} = P[15:8] + A, then P = {c, s, P[7:1]}
  - if P[0]=0: P = P >> 1
  - After 8 steps: RESULT = A*B. FLAG_C = (RESULT[15:8] != 0).
- DIV: 8-bit remainder R=0, quotient Q=A. Each step:
  - T = {R, Q[7]}, 9 bits.
  - Compute T[7:0] − B on the adder.
  - If T[8]=1 or no borrow: R = T[7:0] − B, and shift 1 into Q.
  - Otherwise: R = T[7:0], and shift 0 into Q.
  - Result: RESULT = {R, Q} (remainder high byte, quotient low byte). FLAG_C = 0.
- DIV with B=0
  - RESULT = {A, 8'hFF}
  - ERR = 1
  - FLAG_C = 0
  - ERR is 0 for every other completed operation.

Update and reset rules:
- RESULT, FLAG_C, FLAG_Z and ERR update only on entry to FIN. They are stable between DONE pulses.
- Reset (any state, including mid-MUL/DIV) aborts the operation with no DONE. All outputs = 0, state IDLE.

## Timing
- START sampled high at edge 0 (BUSY=0).
  - BUSY=1 from edge 1 through the last EXEC cycle.
  - DONE=1 for exactly one cycle: after edge 2 for ADD/SUB, after edge 9 for MUL/DIV, after edge 1 for DIV-by-zero.
- BUSY and DONE are never high together.
- Back-to-back: START held high during the DONE cycle is accepted. The next operation begins with no idle cycle. DONE→BUSY gap is 0.
- Outputs are registered; no combinational path from inputs to outputs.
- After RST deasserts, START is accepted at the first rising edge.

## Test plan
- ADD A=8'hF0, B=8'h20: RESULT=16'h0010, FLAG_C=1, FLAG_Z=0, DONE 2 cycles after START.
- SUB A=5, B=7: RESULT=16'h00FE, FLAG_C=1. Then SUB A=9, B=9: RESULT=16'h0000, FLAG_Z=1, FLAG_C=0.
- MUL A=8'hFF, B=8'hFF: RESULT=16'hFE01, FLAG_C=1, BUSY high for 8 cycles, DONE 9 cycles after START. Then MUL A=0, B=123: RESULT=0, FLAG_Z=1.
- DIV A=200, B=7: RESULT=16'h041C, ERR=0. Then DIV A=77, B=0: RESULT=16'h4DFF, ERR=1, DONE 1 cycle after START.
- START pulsed mid-MUL with different A/B/OP: ignored, original product delivered. Back-to-back ADD issued in the DONE cycle completes 2 cycles later.
- RST asserted asynchronously at step 4 of DIV: all outputs 0 immediately, no DONE. The next ADD after release completes normally.
